mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle main controller for the RV32I core. It decodes the instruction-register fields and sequences one instruction over 3–5 clocks, driving the datapath muxes, the ALU, the memory write strobe, the IR and PC enables, and the register-file write enable (WE3). It sits directly upstream of the register file; its `reg_write` output connects straight to WE3.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `op`  in  7  opcode, IR[6:0].
- `funct3`  in  3  IR[14:12].
- `funct7b5`  in  1  IR[30].
- `zero`  in  1  ALU zero flag, combinational, same cycle.
- `pc_write`  out  1  PC register enable.
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  data-memory write strobe.
- `ir_write`  out  1  IR and OldPC enable.
- `result_src`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1 register.
- `alu_src_b`  out  2  ALU B select: 00 = RD2 register, 01 = ImmExt, 10 = constant 4.
- `imm_src`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control`  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- `reg_write`  out  1  register-file WE3.
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction.
- `state`  out  4  current state encoding, for debug.

## Operation
- Moore FSM. The state register is the only storage. All outputs decode from the current state, plus `op`/`funct3`/`funct7b5`/`zero` where stated.
- Encoding and per-state outputs. Any output not listed is 0; `alu_op` is internal.
  - FETCH (0): adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1.
  - DECODE (1): alu_src_a=01, alu_src_b=01, alu_op=00. This precomputes the branch/jump target.
  - MEMADR (2): alu_src_a=10, alu_src_b=01, alu_op=00.
  - MEMREAD (3): adr_src=1, result_src=00.
  - MEMWB (4): result_src=01, reg_write=1, instr_done=1.
  - MEMWRITE (5): adr_src=1, result_src=00, mem_write=1, instr_done=1.
  - EXECUTER (6): alu_src_a=10, alu_src_b=00, alu_op=10.
  - EXECUTEI (7): alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB (8): result_src=00, reg_write=1, instr_done=1.
  - BEQ (9): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1.
  - JAL (10): alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
- `pc_write` = pc_update | (branch & zero).
- Transitions:
  - FETCH→DECODE.
  - DECODE branches on `op`:
    - 0000011 (lw) or 0100011 (sw) → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - any other op → FETCH. The illegal instruction is skipped with no reg/mem write; `instr_done` is not pulsed.
  - MEMADR→MEMREAD if op=0000011, otherwise MEMWRITE.
  - MEMREAD→MEMWB→FETCH; MEMWRITE→FETCH.
  - EXECUTER/EXECUTEI→ALUWB→FETCH.
  - JAL→ALUWB.
  - BEQ→FETCH.
  - Unused encodings 11–15 → FETCH.
- ALU decoder:
  - alu_op 00 → add; alu_op 01 → sub.
  - alu_op 10 decodes funct3:
    - 000 → sub if (op[5] & funct7b5), else add.
    - 010 → slt.
    - 110 → or.
    - 111 → and.
    - all other values → add.
  - alu_op 11 never occurs; it decodes as add.
- `imm_src` is combinational from `op` in every state:
  - sw → 01.
  - beq → 10.
  - jal → 11.
  - all other op values → 00.

## Timing
- Reset: `rst` low forces state=FETCH asynchronously.
- While `rst` is low, `pc_write`, `ir_write`, `mem_write`, `reg_write` and `instr_done` are forced to 0. The other outputs show their FETCH values.
- The first FETCH write cycle is the first rising edge after `rst` deasserts.
- `rst` asserted mid-instruction aborts it immediately, and no write enable is asserted afterward. Register-file writes are qualified by `reg_write`, so none occur during reset.
- Cycles per instruction, FETCH to FETCH: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, illegal 2.
- `op`/`funct*` are sampled combinationally. They are valid from DECODE onward, because the IR is latched at the end of FETCH. During FETCH, only `imm_src` depends on them, and its value there is unused.
- `zero` is used only in BEQ. It is combinational to `pc_write` in that same cycle, with no registered path.
- `reg_write` is high for exactly one cycle per writing instruction. The write lands at the rising edge that exits MEMWB or ALUWB.

## Test plan
- Reset: hold `rst`=0 with op=0110011 → state=0 and all write enables 0. Release → ir_write=1 and pc_write=1 in the first cycle.
- lw: op=0000011 → states 0,1,2,3,4,0. `reg_write`=1 only in state 4 with result_src=01. mem_write=0 throughout.
- sw: op=0100011 → states 0,1,2,5,0. mem_write=1 and adr_src=1 in state 5. imm_src=01. reg_write never 1.
- R-type ALU decode: op=0110011 with funct3=000. funct7b5=1 → alu_control=001 in state 6; funct7b5=0 → 000. funct3=111 → 010; funct3=110 → 011; funct3=010 → 101. I-type op=0010011 with funct3=000 and funct7b5=1 → 000.
- beq: op=1100011 with zero=1 → pc_write=1 in state 9. With zero=0 → pc_write=0. Both cases return to FETCH after 3 cycles.
- jal, illegal and mid-reset:
  - op=1101111 → states 0,1,10,8,0, with pc_write=1 in state 10 and reg_write=1 in state 8.
  - op=0000000 → 0,1,0 with no writes.
  - `rst` pulsed low during state 3 → state=0 immediately, and no reg_write follows.

Source files
------------

// File: rtl/mc_control_if.sv
// Control/status bundle between the multi-cycle controller and the RV32I datapath.
interface mc_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       reg_write;
  logic       instr_done;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, instr_done, state
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, instr_done, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main controller: Moore FSM sequencing each instruction
// over 3-5 clocks, plus ALU and immediate decoders.
module mc_control_fsm (
  input  logic           clk,
  input  logic           rst,
  mc_control_if.master   bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update, branch, reg_wr, mem_wr, ir_wr, done;
  logic       adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    alu_op     = 2'b00;
    pc_update  = 1'b0;
    branch     = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    done       = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    case (state_q)
      FETCH: begin
        ir_wr      = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_wr     = 1'b1;
        done       = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_wr  = 1'b1;
        done    = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_wr = 1'b1;
        done   = 1'b1;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        done      = 1'b1;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    bus.alu_control = 3'b000;
    case (alu_op)
      2'b01: bus.alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.alu_control = 3'b101;
          3'b110:  bus.alu_control = 3'b011;
          3'b111:  bus.alu_control = 3'b010;
          default: bus.alu_control = 3'b000;
        endcase
      end
      default: bus.alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.imm_src = 2'b01;
      OP_BEQ:  bus.imm_src = 2'b10;
      OP_JAL:  bus.imm_src = 2'b11;
      default: bus.imm_src = 2'b00;
    endcase
  end

  // Write enables are gated by rst so nothing commits while reset is held,
  // even in the delta before the async state clear settles.
  assign bus.pc_write   = rst & (pc_update | (branch & bus.zero));
  assign bus.ir_write   = rst & ir_wr;
  assign bus.mem_write  = rst & mem_wr;
  assign bus.reg_write  = rst & reg_wr;
  assign bus.instr_done = rst & done;
  assign bus.adr_src    = adr_src;
  assign bus.result_src = result_src;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed vector table, hand-written
// reset sequences and randomized instructions against a behavioural model.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mc_control_if bus ();
  mc_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] rsrc;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] imm;
    logic [2:0] aluc;
    logic       regw;
    logic       done;
    logic [3:0] st;
  } out_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         cycles;
    logic [2:0] alu_exec;
    logic       br_pcw;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic out_t actual();
    out_t o;
    o.pcw  = bus.pc_write;   o.adr  = bus.adr_src;    o.memw = bus.mem_write;
    o.irw  = bus.ir_write;   o.rsrc = bus.result_src; o.asa  = bus.alu_src_a;
    o.asb  = bus.alu_src_b;  o.imm  = bus.imm_src;    o.aluc = bus.alu_control;
    o.regw = bus.reg_write;  o.done = bus.instr_done; o.st   = bus.state;
    return o;
  endfunction

  // Instruction class -> ordered list of steps it walks through.
  function automatic int path_len(input logic [6:0] op);
    case (op)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int path_state(input logic [6:0] op, input int k);
    int p[5];
    case (op)
      7'b0000011: p = '{0, 1, 2, 3, 4};
      7'b0100011: p = '{0, 1, 2, 5, 0};
      7'b0110011: p = '{0, 1, 6, 8, 0};
      7'b0010011: p = '{0, 1, 7, 8, 0};
      7'b1101111: p = '{0, 1, 10, 8, 0};
      7'b1100011: p = '{0, 1, 9, 0, 0};
      default:    p = '{0, 1, 0, 0, 0};
    endcase
    if (k < 0 || k >= path_len(op)) return 15;
    return p[k];
  endfunction

  function automatic logic [2:0] alu_fn(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000) return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic out_t model(input int s, input logic rstn, input logic [6:0] op,
                                 input logic [2:0] f3, input logic f7, input logic z);
    out_t o = '0;
    o.st  = 4'(s);
    o.imm = (op == 7'b0100011) ? 2'b01 : (op == 7'b1100011) ? 2'b10 :
            (op == 7'b1101111) ? 2'b11 : 2'b00;
    case (s)
      0:  begin o.irw = 1; o.asb = 2'b10; o.rsrc = 2'b10; o.pcw = 1; end
      1:  begin o.asa = 2'b01; o.asb = 2'b01; end
      2:  begin o.asa = 2'b10; o.asb = 2'b01; end
      3:  o.adr = 1;
      4:  begin o.rsrc = 2'b01; o.regw = 1; o.done = 1; end
      5:  begin o.adr = 1; o.memw = 1; o.done = 1; end
      6:  begin o.asa = 2'b10; o.aluc = alu_fn(op, f3, f7); end
      7:  begin o.asa = 2'b10; o.asb = 2'b01; o.aluc = alu_fn(op, f3, f7); end
      8:  begin o.regw = 1; o.done = 1; end
      9:  begin o.asa = 2'b10; o.aluc = 3'b001; o.pcw = z; o.done = 1; end
      10: begin o.asa = 2'b01; o.asb = 2'b10; o.pcw = 1; end
      default: ;
    endcase
    if (!rstn) begin o.pcw = 0; o.irw = 0; o.memw = 0; o.regw = 0; o.done = 0; end
    return o;
  endfunction

  // Runs one instruction starting in FETCH; compares every cycle to the model.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, output int cycles, output logic [2:0] alu_seen,
                           output logic br_pcw);
    cycles = 0; alu_seen = 3'b111; br_pcw = 1'bx;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
      #1;
      check($sformatf("cycle op=%b k=%0d", op, k), 32'(actual()),
            32'(model(path_state(op, k), 1'b1, op, f3, f7, z)));
      if (bus.state == 4'd6 || bus.state == 4'd7) alu_seen = bus.alu_control;
      if (bus.state == 4'd9) br_pcw = bus.pc_write;
      @(posedge clk); #1;
      cycles = k + 1;
      if (bus.state == 4'd0) break;
    end
  endtask

  vec_t vecs[10];
  int         cyc;
  logic [2:0] alu_s;
  logic       bp;

  initial begin
    vecs[0] = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b111, 1'bx};
    vecs[1] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 3'b111, 1'bx};
    vecs[2] = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 1'bx};
    vecs[3] = '{7'b0110011, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'bx};
    vecs[4] = '{7'b0110011, 3'b111, 1'b0, 1'b1, 4, 3'b010, 1'bx};
    vecs[5] = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 1'bx};
    vecs[6] = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b101, 1'bx};
    vecs[7] = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 1'bx};
    vecs[8] = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b111, 1'b1};
    vecs[9] = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b111, 1'b0};

    // Reset held with an R-type opcode on the bus.
    bus.op = 7'b0110011; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'(actual()), 32'(model(0, 1'b0, 7'b0110011, 3'b000, 1'b0, 1'b0)));
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("release ir_write", 32'(bus.ir_write), 32'd1);
    check("release pc_write", 32'(bus.pc_write), 32'd1);

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero, cyc, alu_s, bp);
      check($sformatf("vec%0d cycles", i), 32'(cyc), 32'(vecs[i].cycles));
      check($sformatf("vec%0d alu", i), 32'(alu_s), 32'(vecs[i].alu_exec));
      if (vecs[i].op == 7'b1100011)
        check($sformatf("vec%0d branch pc_write", i), 32'(bp), 32'(vecs[i].br_pcw));
    end

    run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, cyc, alu_s, bp);
    check("jal cycles", 32'(cyc), 32'd4);
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, cyc, alu_s, bp);
    check("illegal cycles", 32'(cyc), 32'd2);

    // lw aborted by reset while in MEMREAD.
    bus.op = 7'b0000011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (bus.state == 4'd3) break;
    end
    check("reached memread", 32'(bus.state), 32'd3);
    rst = 1'b0; #1;
    check("mid reset state", 32'(bus.state), 32'd0);
    check("mid reset outputs", 32'(actual()), 32'(model(0, 1'b0, 7'b0000011, 3'b000, 1'b0, 1'b0)));
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      check("reg_write during reset", 32'(bus.reg_write), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0, cyc, alu_s, bp);
    check("post reset illegal cycles", 32'(cyc), 32'd2);

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      logic [6:0] rop;
      logic [6:0] ops[7];
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0000000};
      rop = ($urandom_range(0, 7) == 7) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom), cyc, alu_s, bp);
      check($sformatf("rand%0d cycles", n), 32'(cyc), 32'(path_len(rop)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
